// File: rtl/delay_param_controller.sv
// rtl/delay_param_controller.sv - click-free slewing and mode sequencing of delay_effect controls
// Optional tap-tempo delay measurement: define DELAY_CTRL_TAP_TEMPO_EN.
module delay_param_controller #(
  parameter int ADDR_WIDTH     = 16,
  parameter int FEEDBACK_WIDTH = 8,
  parameter int DELAY_STEP     = 4,
  parameter int MIX_STEP       = 1,
  parameter int FLUSH_SAMPLES  = 64,
  parameter int DEFAULT_DELAY  = 4800
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [1:0]                cfg_addr,
  input  logic [15:0]               cfg_data,
  input  logic                      tap,
  output logic [ADDR_WIDTH-1:0]     delay_samples,
  output logic [FEEDBACK_WIDTH-1:0] feedback_amount,
  output logic [7:0]                effect_amount,
  output logic                      mode,
  output logic                      busy
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_SWAP     = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam int FC_W = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [FC_W-1:0]           FLUSH_LAST = FC_W'(FLUSH_SAMPLES - 1);
  localparam logic [ADDR_WIDTH-1:0]     D_STEP     = ADDR_WIDTH'(DELAY_STEP);
  localparam logic [FEEDBACK_WIDTH-1:0] FB_STEP    = FEEDBACK_WIDTH'(MIX_STEP);
  localparam logic [7:0]                MX_STEP    = 8'(MIX_STEP);
  localparam logic [ADDR_WIDTH-1:0]     DLY_RESET  = ADDR_WIDTH'(DEFAULT_DELAY);

  logic [1:0]                state;
  logic [ADDR_WIDTH-1:0]     tgt_delay;
  logic [FEEDBACK_WIDTH-1:0] tgt_fb;
  logic [7:0]                tgt_mix;
  logic                      tgt_mode;
  logic [FC_W-1:0]           flush_cnt;

  logic                  cfg_accept;
  logic                  cfg_delay_wr;
  logic [ADDR_WIDTH-1:0] cfg_delay_raw;
  logic [ADDR_WIDTH-1:0] cfg_delay;

  assign cfg_ready     = (state == ST_RUN);
  assign cfg_accept    = cfg_valid && cfg_ready;
  assign cfg_delay_wr  = cfg_accept && (cfg_addr == 2'd0);
  assign cfg_delay_raw = cfg_data[ADDR_WIDTH-1:0];
  // A zero delay would read the sample being written; store it as one.
  assign cfg_delay     = (cfg_delay_raw == '0) ? ADDR_WIDTH'(1) : cfg_delay_raw;

  assign busy = (state != ST_RUN) || (delay_samples != tgt_delay) ||
                (feedback_amount != tgt_fb) || (effect_amount != tgt_mix);

  function automatic logic [ADDR_WIDTH-1:0] slew_delay(input logic [ADDR_WIDTH-1:0] cur,
                                                       input logic [ADDR_WIDTH-1:0] tgt);
    if (tgt > cur)      return ((tgt - cur) > D_STEP) ? cur + D_STEP : tgt;
    else if (cur > tgt) return ((cur - tgt) > D_STEP) ? cur - D_STEP : tgt;
    else                return cur;
  endfunction

  function automatic logic [FEEDBACK_WIDTH-1:0] slew_fb(input logic [FEEDBACK_WIDTH-1:0] cur,
                                                        input logic [FEEDBACK_WIDTH-1:0] tgt);
    if (tgt > cur)      return ((tgt - cur) > FB_STEP) ? cur + FB_STEP : tgt;
    else if (cur > tgt) return ((cur - tgt) > FB_STEP) ? cur - FB_STEP : tgt;
    else                return cur;
  endfunction

  function automatic logic [7:0] slew_mix(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur)      return ((tgt - cur) > MX_STEP) ? cur + MX_STEP : tgt;
    else if (cur > tgt) return ((cur - tgt) > MX_STEP) ? cur - MX_STEP : tgt;
    else                return cur;
  endfunction

`ifdef DELAY_CTRL_TAP_TEMPO_EN
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  logic                  tap_q;
  logic                  meas_active;
  logic [ADDR_WIDTH-1:0] tap_cnt;
  logic                  tap_rise;
  logic                  tap_load;
  logic [ADDR_WIDTH-1:0] tap_value;

  assign tap_rise  = tap && !tap_q;
  assign tap_load  = tap_rise && meas_active;
  assign tap_value = (tap_cnt == '0) ? ADDR_WIDTH'(1) : tap_cnt;

  // Tap measurement: first rising tap starts counting samples, next one ends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q       <= 1'b0;
      meas_active <= 1'b0;
      tap_cnt     <= '0;
    end else begin
      tap_q <= tap;
      if (tap_rise) begin
        if (meas_active) begin
          meas_active <= 1'b0;
        end else begin
          meas_active <= 1'b1;
          tap_cnt     <= '0;
        end
      end else if (meas_active && sample_valid) begin
        // Reaching the all-ones count abandons the measurement.
        if (tap_cnt == CNT_LAST) meas_active <= 1'b0;
        tap_cnt <= tap_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Delay target: cfg writes take priority over a simultaneous tap load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               tgt_delay <= DLY_RESET;
    else if (cfg_delay_wr) tgt_delay <= cfg_delay;
    else if (tap_load)     tgt_delay <= tap_value;
  end
`else
  logic unused_tap;
  assign unused_tap = tap;

  // Delay target: updated from cfg writes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               tgt_delay <= DLY_RESET;
    else if (cfg_delay_wr) tgt_delay <= cfg_delay;
  end
`endif

  // Remaining targets, output slewing and the fade-out / swap / fade-in sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_RUN;
      delay_samples   <= DLY_RESET;
      feedback_amount <= '0;
      effect_amount   <= '0;
      mode            <= 1'b0;
      tgt_fb          <= '0;
      tgt_mix         <= '0;
      tgt_mode        <= 1'b0;
      flush_cnt       <= '0;
    end else begin
      if (cfg_accept) begin
        case (cfg_addr)
          2'd1: tgt_fb  <= cfg_data[FEEDBACK_WIDTH-1:0];
          2'd2: tgt_mix <= cfg_data[7:0];
          2'd3: begin
            if (cfg_data[0] != mode) begin
              tgt_mode <= cfg_data[0];
              state    <= ST_FADE_OUT;
            end
          end
          default: ;
        endcase
      end

      case (state)
        ST_RUN: begin
          if (sample_valid) begin
            delay_samples   <= slew_delay(delay_samples, tgt_delay);
            feedback_amount <= slew_fb(feedback_amount, tgt_fb);
            effect_amount   <= slew_mix(effect_amount, tgt_mix);
          end
        end
        ST_FADE_OUT: begin
          // Completion is checked every clk so an already-silent fade costs one cycle.
          if (feedback_amount == '0 && effect_amount == '0) begin
            mode      <= tgt_mode;
            flush_cnt <= '0;
            state     <= ST_SWAP;
          end else if (sample_valid) begin
            feedback_amount <= slew_fb(feedback_amount, '0);
            effect_amount   <= slew_mix(effect_amount, 8'd0);
          end
        end
        ST_SWAP: begin
          if (sample_valid) begin
            if (flush_cnt == FLUSH_LAST) state <= ST_FADE_IN;
            else                         flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        default: begin
          if (feedback_amount == tgt_fb && effect_amount == tgt_mix) begin
            state <= ST_RUN;
          end else if (sample_valid) begin
            feedback_amount <= slew_fb(feedback_amount, tgt_fb);
            effect_amount   <= slew_mix(effect_amount, tgt_mix);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_param_controller.sv
// tb/tb_delay_param_controller.sv - scoreboard bench for delay_param_controller
module tb_delay_param_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_addr = 2'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        tap = 1'b0;
  logic [15:0] delay_samples;
  logic [7:0]  feedback_amount;
  logic [7:0]  effect_amount;
  logic        mode;
  logic        busy;

  delay_param_controller dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .tap(tap), .delay_samples(delay_samples), .feedback_amount(feedback_amount),
    .effect_amount(effect_amount), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [7:0]  fb;
    logic [7:0]  mix;
    logic        mode;
    logic        busy;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic chk = 1'b0;
  logic chk_seen = 1'b0;
  exp_t nx;

  function automatic exp_t mk(input string n, input logic [15:0] d, input logic [7:0] fb,
                              input logic [7:0] mix, input logic md, input logic bz, input logic rd);
    exp_t e;
    e.name = n; e.d = d; e.fb = fb; e.mix = mix; e.mode = md; e.busy = bz; e.rdy = rd;
    return e;
  endfunction

  // Remember which edges carry an expectation.
  always @(posedge clk) chk_seen <= chk;

  // Monitor: pop and compare one expectation per flagged edge, half a cycle later.
  always @(negedge clk) begin
    if (chk_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (delay_samples !== e.d || feedback_amount !== e.fb || effect_amount !== e.mix ||
            mode !== e.mode || busy !== e.busy || cfg_ready !== e.rdy) begin
          failures++;
          $display("FAIL %s: got d=%0d fb=%0d mix=%0d mode=%0d busy=%0d rdy=%0d, want d=%0d fb=%0d mix=%0d mode=%0d busy=%0d rdy=%0d",
                   e.name, delay_samples, feedback_amount, effect_amount, mode, busy, cfg_ready,
                   e.d, e.fb, e.mix, e.mode, e.busy, e.rdy);
        end
      end
    end
  end

  task automatic tick(input logic sv, input logic do_chk, input exp_t e);
    sample_valid = sv;
    chk = do_chk;
    if (do_chk) exp_q.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
    chk = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] dt, input logic sv,
                    input logic do_chk, input exp_t e);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = dt;
    tick(sv, do_chk, e);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nx = mk("none", 16'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    tick(1'b0, 1'b1, mk("reset", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));

    // Mix ramp one step per sample
    wr(2'd2, 16'd10, 1'b0, 1'b1, mk("mix_wr", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    for (int i = 1; i <= 10; i++)
      tick(1'b1, 1'b1, mk("mix_ramp", 16'd4800, 8'd0, 8'(i), 1'b0, i < 10, 1'b1));

    // Delay ramp by 4, no overshoot; zero write targets 1; no sample -> no change
    wr(2'd0, 16'd4810, 1'b0, 1'b0, nx);
    for (int i = 1; i <= 3; i++)
      tick(1'b1, 1'b1, mk("dly_ramp", (i == 3) ? 16'd4810 : 16'(4800 + 4 * i), 8'd0, 8'd10, 1'b0, i < 3, 1'b1));
    wr(2'd0, 16'd0, 1'b0, 1'b0, nx);
    tick(1'b0, 1'b1, mk("dly_no_sample", 16'd4810, 8'd0, 8'd10, 1'b0, 1'b1, 1'b1));
    tick(1'b1, 1'b1, mk("dly_zero_tgt", 16'd4806, 8'd0, 8'd10, 1'b0, 1'b1, 1'b1));
    wr(2'd0, 16'd4806, 1'b0, 1'b1, mk("dly_hold", 16'd4806, 8'd0, 8'd10, 1'b0, 1'b0, 1'b1));

    // Write and sample on the same edge: the step uses the old target
    wr(2'd2, 16'd12, 1'b1, 1'b1, mk("old_tgt_step", 16'd4806, 8'd0, 8'd10, 1'b0, 1'b1, 1'b1));
    tick(1'b1, 1'b1, mk("new_tgt_11", 16'd4806, 8'd0, 8'd11, 1'b0, 1'b1, 1'b1));
    tick(1'b1, 1'b1, mk("new_tgt_12", 16'd4806, 8'd0, 8'd12, 1'b0, 1'b0, 1'b1));
    wr(2'd2, 16'd10, 1'b0, 1'b0, nx);
    tick(1'b1, 1'b0, nx);
    tick(1'b1, 1'b1, mk("mix_back", 16'd4806, 8'd0, 8'd10, 1'b0, 1'b0, 1'b1));

    // Feedback ramp
    wr(2'd1, 16'd5, 1'b0, 1'b0, nx);
    for (int i = 1; i <= 5; i++)
      tick(1'b1, 1'b1, mk("fb_ramp", 16'd4806, 8'(i), 8'd10, 1'b0, i < 5, 1'b1));

    // Mode change: fade out, swap, flush 64 samples, fade in
    wr(2'd3, 16'd1, 1'b0, 1'b1, mk("mode_wr", 16'd4806, 8'd5, 8'd10, 1'b0, 1'b1, 1'b0));
    for (int i = 1; i <= 10; i++)
      tick(1'b1, 1'b1, mk("fade_out", 16'd4806, (i < 5) ? 8'(5 - i) : 8'd0, 8'(10 - i), 1'b0, 1'b1, 1'b0));
    tick(1'b0, 1'b1, mk("swap_enter", 16'd4806, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0));
    wr(2'd2, 16'd50, 1'b0, 1'b1, mk("swap_wr_ignored", 16'd4806, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0));
    for (int i = 1; i <= 64; i++)
      tick(1'b1, 1'b1, mk("swap_hold", 16'd4806, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0));
    for (int i = 1; i <= 10; i++)
      tick(1'b1, 1'b1, mk("fade_in", 16'd4806, (i < 5) ? 8'(i) : 8'd5, 8'(i), 1'b1, 1'b1, 1'b0));
    tick(1'b0, 1'b1, mk("run_again", 16'd4806, 8'd5, 8'd10, 1'b1, 1'b0, 1'b1));

    // Writing the current mode is a no-op
    wr(2'd3, 16'd1, 1'b0, 1'b1, mk("mode_same", 16'd4806, 8'd5, 8'd10, 1'b1, 1'b0, 1'b1));
    tick(1'b0, 1'b1, mk("mode_same_idle", 16'd4806, 8'd5, 8'd10, 1'b1, 1'b0, 1'b1));

    // Reset during SWAP
    wr(2'd3, 16'd0, 1'b0, 1'b0, nx);
    for (int i = 1; i <= 10; i++) tick(1'b1, 1'b0, nx);
    tick(1'b0, 1'b0, nx);
    tick(1'b1, 1'b1, mk("swap2", 16'd4806, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    tick(1'b0, 1'b1, mk("rst_in_swap", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    rst = 1'b0;

    // Reset during FADE_OUT drops the pending mode change
    wr(2'd2, 16'd2, 1'b0, 1'b0, nx);
    tick(1'b1, 1'b0, nx);
    tick(1'b1, 1'b0, nx);
    wr(2'd3, 16'd1, 1'b0, 1'b0, nx);
    tick(1'b1, 1'b1, mk("fade_before_rst", 16'd4800, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0));
    rst = 1'b1;
    tick(1'b0, 1'b1, mk("rst_in_fade", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    rst = 1'b0;
    for (int i = 1; i <= 3; i++)
      tick(1'b1, 1'b1, mk("no_pending_mode", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));

`ifdef DELAY_CTRL_TAP_TEMPO_EN
    // Taps 1000 samples apart load the delay target
    tap = 1'b1; tick(1'b0, 1'b0, nx); tap = 1'b0;
    for (int i = 1; i <= 1000; i++) tick(1'b1, 1'b0, nx);
    tap = 1'b1;
    tick(1'b0, 1'b1, mk("tap_load", 16'd4800, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    tap = 1'b0;
    for (int i = 1; i <= 3; i++)
      tick(1'b1, 1'b1, mk("tap_ramp", 16'(4800 - 4 * i), 8'd0, 8'd0, 1'b0, 1'b1, 1'b1));
    for (int i = 1; i <= 1000; i++) tick(1'b1, 1'b0, nx);
    tick(1'b1, 1'b1, mk("tap_done", 16'd1000, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));

    // A measurement left running saturates and is discarded
    tap = 1'b1; tick(1'b0, 1'b0, nx); tap = 1'b0;
    for (int i = 1; i <= 65535; i++) tick(1'b1, 1'b0, nx);
    tap = 1'b1; tick(1'b0, 1'b0, nx); tap = 1'b0;
    tick(1'b1, 1'b1, mk("tap_saturate", 16'd1000, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1));
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
